ex_mem_stage: RTL and testbench

- Pipeline boundary directly downstream of the ALU.
- Captures the ALU result and zero flag together with the control bits that travel with them (destination register, write/memory controls, store data, branch target).
- Presents them to the memory stage through a valid/ready handshake.
- Resolves equal-branches from the zero flag, emits a one-cycle redirect, and exposes a forwarding tap back to the ALU operand muxes.

---
 rtl/ex_mem_pkg.sv | 24 ++
 rtl/pipe_skid_buf.sv | 72 +++++++
 rtl/ex_mem_stage.sv | 110 +++++++++++
 tb/tb_ex_mem_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_pkg
// Brief    : Shared widths and the EX/MEM entry layout.
// Revision : 1.0
// ============================================================================
package ex_mem_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] store_data;
        logic [REG_W-1:0]  rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } ex_mem_entry_t;

endpackage : ex_mem_pkg
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_buf
// Brief    : Two-slot skid FIFO; ready depends only on the registered count.
// Revision : 1.0
// ============================================================================
module pipe_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic [1:0]       r_count;
    logic [WIDTH-1:0] r_slot0;
    logic [WIDTH-1:0] r_slot1;
    logic             w_push;
    logic             w_pop;

    assign o_ready = (r_count != 2'd2);
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_slot0;

    // Flush drops any push; a pop this cycle is still seen by the consumer.
    assign w_push  = i_valid & o_ready & ~i_flush;
    assign w_pop   = o_valid & i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        r_slot0 <= i_data;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_slot0 <= i_data;
                    end else if (w_push) begin
                        r_slot1 <= i_data;
                        r_count <= 2'd2;
                    end else if (w_pop) begin
                        r_count <= 2'd0;
                    end
                end
                2'd2: begin
                    if (w_pop) begin
                        r_slot0 <= r_slot1;
                        r_count <= 2'd1;
                    end
                end
                default: r_count <= 2'd0;
            endcase
        end
    end

endmodule : pipe_skid_buf
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage
// Brief    : EX/MEM boundary: skid buffer, beq resolution, forwarding tap.
// Revision : 1.0
// ============================================================================
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = ex_mem_pkg::DATA_W,
    parameter int REG_W  = ex_mem_pkg::REG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic [DATA_W-1:0] store_data,
    input  logic [REG_W-1:0]  rd,
    input  logic              reg_write,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              branch,
    input  logic [DATA_W-1:0] branch_target,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              redirect_valid,
    output logic [DATA_W-1:0] redirect_pc,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_rd,
    output logic [DATA_W-1:0] fwd_data
);

    localparam int c_ENTRY_W = $bits(ex_mem_entry_t);

    ex_mem_entry_t        w_in_entry;
    ex_mem_entry_t        w_out_entry;
    logic [c_ENTRY_W-1:0] w_in_bits;
    logic [c_ENTRY_W-1:0] w_out_bits;
    logic                 w_accept;
    logic                 r_redirect_valid;
    logic [DATA_W-1:0]    r_redirect_pc;

    // Branches never write back or touch memory, whatever the decoder said.
    always_comb begin
        w_in_entry            = '0;
        w_in_entry.alu_result = alu_result;
        w_in_entry.store_data = store_data;
        w_in_entry.rd         = rd;
        w_in_entry.reg_write  = reg_write & ~branch;
        w_in_entry.mem_read   = mem_read  & ~branch;
        w_in_entry.mem_write  = mem_write & ~branch;
    end

    assign w_in_bits   = w_in_entry;
    assign w_out_entry = w_out_bits;

    pipe_skid_buf #(
        .WIDTH (c_ENTRY_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_in_bits),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_out_bits)
    );

    // Redirect keys off the handshake alone so a same-cycle flush cannot mask it.
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= w_accept & branch & alu_zero;
            if (w_accept && branch && alu_zero) begin
                r_redirect_pc <= branch_target;
            end
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

    assign out_alu_result = w_out_entry.alu_result;
    assign out_store_data = w_out_entry.store_data;
    assign out_rd         = w_out_entry.rd;
    assign out_reg_write  = w_out_entry.reg_write;
    assign out_mem_read   = w_out_entry.mem_read;
    assign out_mem_write  = w_out_entry.mem_write;

    assign fwd_valid = out_valid & out_reg_write & ~out_mem_read & (out_rd != REG_ZERO);
    assign fwd_rd    = out_rd;
    assign fwd_data  = out_alu_result;

endmodule : ex_mem_stage
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_stage
// Brief    : Directed self-checking bench for ex_mem_stage.
// Revision : 1.0
// ============================================================================
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] alu_result = '0;
    logic        alu_zero = 1'b0;
    logic [31:0] store_data = '0;
    logic [4:0]  rd = '0;
    logic        reg_write = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] branch_target = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_alu_result;
    logic [31:0] out_store_data;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_result     (alu_result),
        .alu_zero       (alu_zero),
        .store_data     (store_data),
        .rd             (rd),
        .reg_write      (reg_write),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .branch         (branch),
        .branch_target  (branch_target),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_alu_result (out_alu_result),
        .out_store_data (out_store_data),
        .out_rd         (out_rd),
        .out_reg_write  (out_reg_write),
        .out_mem_read   (out_mem_read),
        .out_mem_write  (out_mem_write),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fwd_valid      (fwd_valid),
        .fwd_rd         (fwd_rd),
        .fwd_data       (fwd_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid      = 1'b0;
        alu_result    = '0;
        alu_zero      = 1'b0;
        store_data    = '0;
        rd            = '0;
        reg_write     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        branch        = 1'b0;
        branch_target = '0;
        flush         = 1'b0;
    endtask

    task automatic put(input logic [31:0] res, input logic [4:0] r, input logic rw,
                       input logic mr, input logic br, input logic z, input logic [31:0] tgt);
        idle();
        in_valid      = 1'b1;
        alu_result    = res;
        store_data    = res ^ 32'hFFFF_0000;
        rd            = r;
        reg_write     = rw;
        mem_read      = mr;
        branch        = br;
        alu_zero      = z;
        branch_target = tgt;
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_redirect_valid", {31'b0, redirect_valid}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_out_alu_result", out_alu_result, 32'd0);
        #10 rst_n = 1'b1;

        // Fill to two entries, second one a taken branch, then reset asynchronously
        out_ready = 1'b0;
        put(32'h100, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        put(32'h101, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 32'h200);
        tick();
        idle();
        check("full_in_ready", {31'b0, in_ready}, 32'd0);
        check("full_redirect", {31'b0, redirect_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'b0, out_valid}, 32'd0);
        check("arst_in_ready", {31'b0, in_ready}, 32'd1);
        check("arst_redirect", {31'b0, redirect_valid}, 32'd0);
        check("arst_redirect_pc", redirect_pc, 32'd0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        check("post_rst_no_redirect", {31'b0, redirect_valid}, 32'd0);
        check("post_rst_empty", {31'b0, out_valid}, 32'd0);
        put(32'h5, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
        check("post_rst_valid", {31'b0, out_valid}, 32'd1);
        check("post_rst_result", out_alu_result, 32'h5);
        tick();

        // Backpressure: two pushes fill the buffer, third ignored
        out_ready = 1'b0;
        put(32'h11, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check("bp_ready_after_1", {31'b0, in_ready}, 32'd1);
        put(32'h22, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check("bp_ready_after_2", {31'b0, in_ready}, 32'd0);
        put(32'h33, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
        check("bp_head_11", out_alu_result, 32'h11);
        check("bp_store_11", out_store_data, 32'hFFFF_0011);
        out_ready = 1'b1;
        tick();
        check("bp_head_22", out_alu_result, 32'h22);
        check("bp_ready_after_pop", {31'b0, in_ready}, 32'd1);
        tick();
        check("bp_drained", {31'b0, out_valid}, 32'd0);

        // Streaming at full rate
        put(32'hA, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check("st_A", out_alu_result, 32'hA);
        check("st_ready_A", {31'b0, in_ready}, 32'd1);
        put(32'hB, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check("st_B", out_alu_result, 32'hB);
        check("st_ready_B", {31'b0, in_ready}, 32'd1);
        put(32'hC, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
        check("st_C", out_alu_result, 32'hC);
        check("st_valid_C", {31'b0, out_valid}, 32'd1);
        tick();
        check("st_empty", {31'b0, out_valid}, 32'd0);

        // Taken and not-taken branches
        put(32'h99, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 32'h40);
        mem_write = 1'b1;
        tick();
        idle();
        check("br_pulse", {31'b0, redirect_valid}, 32'd1);
        check("br_pc", redirect_pc, 32'h40);
        check("br_mask_rw", {31'b0, out_reg_write}, 32'd0);
        check("br_mask_mr", {31'b0, out_mem_read}, 32'd0);
        check("br_mask_mw", {31'b0, out_mem_write}, 32'd0);
        check("br_valid", {31'b0, out_valid}, 32'd1);
        tick();
        check("br_pulse_end", {31'b0, redirect_valid}, 32'd0);
        check("br_pc_hold", redirect_pc, 32'h40);
        put(32'h98, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 32'h80);
        tick();
        idle();
        check("nt_no_pulse", {31'b0, redirect_valid}, 32'd0);
        check("nt_pc_hold", redirect_pc, 32'h40);
        tick();

        // Flush with a full buffer and a pending input
        out_ready = 1'b0;
        put(32'h1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        put(32'h2, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        put(32'h3, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        flush = 1'b1;
        tick();
        idle();
        check("fl_full_valid", {31'b0, out_valid}, 32'd0);
        check("fl_full_ready", {31'b0, in_ready}, 32'd1);

        // Flush with one entry: same-cycle push dropped, taken-branch pulse kept
        put(32'h4, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        put(32'h5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1234);
        flush = 1'b1;
        tick();
        idle();
        check("fl_one_valid", {31'b0, out_valid}, 32'd0);
        check("fl_redirect_kept", {31'b0, redirect_valid}, 32'd1);
        check("fl_redirect_pc", redirect_pc, 32'h1234);
        out_ready = 1'b1;
        put(32'h77, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
        check("fl_after_push", out_alu_result, 32'h77);
        tick();
        check("fl_after_empty", {31'b0, out_valid}, 32'd0);

        // Forwarding tap
        out_ready = 1'b0;
        put(32'hDEAD_BEEF, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check("fwd_valid", {31'b0, fwd_valid}, 32'd1);
        check("fwd_rd", {27'b0, fwd_rd}, 32'd7);
        check("fwd_data", fwd_data, 32'hDEAD_BEEF);
        out_ready = 1'b1;
        put(32'h0BAD_F00D, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check("fwd_r0_valid", {31'b0, fwd_valid}, 32'd0);
        check("fwd_r0_rw_kept", {31'b0, out_reg_write}, 32'd1);
        check("fwd_r0_head", out_alu_result, 32'h0BAD_F00D);
        put(32'h1000, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
        check("fwd_load_valid", {31'b0, fwd_valid}, 32'd0);
        check("fwd_load_head_valid", {31'b0, out_valid}, 32'd1);
        tick();
        check("fwd_empty_valid", {31'b0, fwd_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_ex_mem_stage
`default_nettype wire
